frame_seq_ctrl: RTL and testbench

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

---
 rtl/frame_seq_pkg.sv | 14 +
 rtl/frame_pos_cnt.sv | 56 +++++
 rtl/frame_seq_ctrl.sv | 112 +++++++++++
 tb/tb_frame_seq_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared types and default geometry widths for the frame sequencing controller.
package frame_seq_pkg;

    localparam int COL_W_DEF = 11;
    localparam int ROW_W_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/frame_pos_cnt.sv
// Column/row raster position counter with wrap at the latched frame limits.
module frame_pos_cnt
    import frame_seq_pkg::*;
#(
    parameter int COL_W = COL_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [COL_W-1:0] width_i,
    input  logic [ROW_W-1:0] height_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             eol;

    assign eol    = (col_q == width_i);
    assign last_o = eol & (row_q == height_i);
    assign col_o  = col_q;
    assign row_o  = row_q;

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (eol) begin
                col_d = '0;
                row_d = (row_q == height_i) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: gates pixels into a one-entry grayscale stage and tags its output with raster markers.
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter int COL_W = COL_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [COL_W-1:0] width_i,
    input  logic [ROW_W-1:0] height_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             dp_valid_o,
    input  logic             dp_ready_i,
    input  logic             dp_valid_i,
    output logic             dp_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             sof_o,
    output logic             eol_o,
    output logic             eof_o,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o
);

    state_e           state_q, state_d;
    logic [COL_W-1:0] width_q;
    logic [ROW_W-1:0] height_q;

    logic             start_acc;
    logic             in_hs;
    logic             out_hs;
    logic             in_last;
    logic             out_last;
    logic [COL_W-1:0] unused_in_col;
    logic [ROW_W-1:0] unused_in_row;

    assign start_acc   = (state_q == ST_IDLE) & start_i;
    assign in_ready_o  = (state_q == ST_RUN) & dp_ready_i;
    assign dp_valid_o  = (state_q == ST_RUN) & in_valid_i;
    assign in_hs       = in_valid_i & in_ready_o;

    assign out_valid_o = dp_valid_i;
    assign dp_ready_o  = out_ready_i;
    assign out_hs      = out_valid_o & out_ready_i &
                         ((state_q == ST_RUN) | (state_q == ST_DRAIN));

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign sof_o  = busy_o & (col_o == '0) & (row_o == '0);
    assign eol_o  = busy_o & (col_o == width_q);
    assign eof_o  = busy_o & out_last;

    // Input side only needs its last flag; its position is not exported.
    frame_pos_cnt #(.COL_W(COL_W), .ROW_W(ROW_W)) u_in_cnt (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (start_acc),
        .en_i     (in_hs),
        .width_i  (width_q),
        .height_i (height_q),
        .col_o    (unused_in_col),
        .row_o    (unused_in_row),
        .last_o   (in_last)
    );

    frame_pos_cnt #(.COL_W(COL_W), .ROW_W(ROW_W)) u_out_cnt (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (start_acc),
        .en_i     (out_hs),
        .width_i  (width_q),
        .height_i (height_q),
        .col_o    (col_o),
        .row_o    (row_o),
        .last_o   (out_last)
    );

    // The eof handshake is tested first so a coincident last input skips DRAIN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_RUN;
            ST_RUN: begin
                if (out_hs && out_last)     state_d = ST_DONE;
                else if (in_hs && in_last)  state_d = ST_DRAIN;
            end
            ST_DRAIN: if (out_hs && out_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            width_q  <= '0;
            height_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                width_q  <= width_i;
                height_q <= height_i;
            end
        end
    end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Randomized bench for frame_seq_ctrl with a one-entry stage model and a raster-order reference.
module tb_frame_seq_ctrl;

    localparam int CW = 11;
    localparam int RW = 11;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_i;
    logic [CW-1:0] width_i;
    logic [RW-1:0] height_i;
    logic          busy_o, done_o;
    logic          in_valid_i, in_ready_o;
    logic          dp_valid_o, dp_ready_i;
    logic          dp_valid_i, dp_ready_o;
    logic          out_valid_o, out_ready_i;
    logic          sof_o, eol_o, eof_o;
    logic [CW-1:0] col_o;
    logic [RW-1:0] row_o;

    int n_checks = 0;
    int n_errs   = 0;
    int stall_seen = 0;

    always #5 clk = ~clk;

    frame_seq_ctrl #(.COL_W(CW), .ROW_W(RW)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start_i),
        .width_i     (width_i),
        .height_i    (height_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .dp_valid_o  (dp_valid_o),
        .dp_ready_i  (dp_ready_i),
        .dp_valid_i  (dp_valid_i),
        .dp_ready_o  (dp_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sof_o       (sof_o),
        .eol_o       (eol_o),
        .eof_o       (eof_o),
        .col_o       (col_o),
        .row_o       (row_o)
    );

    // Behavioural one-entry grayscale stage: accepts while empty or while draining.
    logic st_full;
    logic st_ready;
    assign st_ready   = !st_full || dp_ready_o;
    assign dp_ready_i = st_ready;
    assign dp_valid_i = st_full;

    always @(posedge clk or negedge rstn) begin
        if (!rstn)                       st_full <= 1'b0;
        else if (dp_valid_o && st_ready) st_full <= 1'b1;
        else if (st_full && dp_ready_o)  st_full <= 1'b0;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_hold(input int cycles);
        in_valid_i = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("idle_busy",     int'(busy_o),     0);
            check("idle_done",     int'(done_o),     0);
            check("idle_in_ready", int'(in_ready_o), 0);
            check("idle_dp_valid", int'(dp_valid_o), 0);
            check("idle_sof",      int'(sof_o),      0);
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
    endtask

    // Drives one frame; the expected output order is plain raster order of (w+1)x(h+1) pixels.
    task automatic run_frame(input int w, input int h, input int vp, input int rp,
                             input bit poke, input int abort_after, output int busy_cyc);
        int n, sent, got, cyc, last_out_cyc, done_cyc;
        bit done_seen;
        n = (w + 1) * (h + 1);
        sent = 0; got = 0; cyc = 0; busy_cyc = 0;
        last_out_cyc = -1; done_cyc = -1; done_seen = 0;

        width_i = CW'(w); height_i = RW'(h);
        start_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;

        while (!done_seen && cyc < 50 * n + 50) begin
            in_valid_i  = ($urandom_range(99) < vp);
            out_ready_i = ($urandom_range(99) < rp);
            if (poke && cyc == 2) begin
                start_i  = 1'b1;
                width_i  = CW'(w + 3);
                height_i = RW'(h + 2);
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            if (busy_o) busy_cyc++;
            if (sent < n) begin
                check("run_in_ready", int'(in_ready_o), int'(st_ready));
                check("run_dp_valid", int'(dp_valid_o), int'(in_valid_i));
                if (!in_ready_o && st_full) stall_seen++;
            end else begin
                check("post_in_ready", int'(in_ready_o), 0);
                check("post_dp_valid", int'(dp_valid_o), 0);
            end
            check("out_valid_pass", int'(out_valid_o), int'(st_full));
            check("dp_ready_pass",  int'(dp_ready_o),  int'(out_ready_i));
            if (in_valid_i && in_ready_o) sent++;
            if (out_valid_o && out_ready_i) begin
                check("pix_col", int'(col_o), got % (w + 1));
                check("pix_row", int'(row_o), got / (w + 1));
                check("pix_sof", int'(sof_o), int'(got == 0));
                check("pix_eol", int'(eol_o), int'((got % (w + 1)) == w));
                check("pix_eof", int'(eof_o), int'(got == n - 1));
                if (got == n - 1) last_out_cyc = cyc;
                got++;
                if (got == abort_after) break;
            end
            if (done_o) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;

        if (abort_after > 0) begin
            check("abort_no_done", int'(done_seen), 0);
            @(posedge clk); #1;
            rstn = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
            #1;
            check("abort_busy",     int'(busy_o),     0);
            check("abort_done",     int'(done_o),     0);
            check("abort_in_ready", int'(in_ready_o), 0);
            check("abort_dp_valid", int'(dp_valid_o), 0);
            check("abort_col",      int'(col_o),      0);
            check("abort_row",      int'(row_o),      0);
            repeat (2) begin
                @(negedge clk);
                check("abort_done_hold", int'(done_o), 0);
            end
            @(posedge clk); #1;
            rstn = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        end else begin
            check("done_seen", int'(done_seen), 1);
            check("out_count", got,  n);
            check("in_count",  sent, n);
            check("done_lat",  done_cyc, last_out_cyc + 1);
            idle_hold(3);
        end
    endtask

    initial begin
        int bc;
        rstn = 1'b0; start_i = 1'b0; width_i = '0; height_i = '0;
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        #3;
        check("rst_busy",     int'(busy_o),     0);
        check("rst_done",     int'(done_o),     0);
        check("rst_in_ready", int'(in_ready_o), 0);
        check("rst_dp_valid", int'(dp_valid_o), 0);
        check("rst_sof",      int'(sof_o),      0);
        check("rst_col",      int'(col_o),      0);
        check("rst_row",      int'(row_o),      0);
        @(posedge clk); #1;
        rstn = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        @(posedge clk); #1;

        run_frame(3, 1, 100, 100, 1'b0, 0, bc);
        check("busy_4x2", bc, 10);

        stall_seen = 0;
        run_frame(3, 1, 100, 50, 1'b0, 0, bc);
        check("stall_seen", int'(stall_seen > 0), 1);

        run_frame(0, 0, 100, 100, 1'b0, 0, bc);
        check("busy_1x1", bc, 3);

        run_frame(3, 1, 100, 100, 1'b1, 0, bc);
        check("busy_poke", bc, 10);

        run_frame(3, 1, 100, 100, 1'b0, 3, bc);
        run_frame(3, 1, 100, 100, 1'b0, 0, bc);
        check("busy_after_abort", bc, 10);

        for (int f = 0; f < 8; f++) begin
            run_frame(int'($urandom_range(4)), int'($urandom_range(3)),
                      int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      1'b0, 0, bc);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
